// File: rtl/i_o_pkg.sv
// Shared I/O definitions: data width, receive buffer depth and the serial rx FSM states.
package i_o_pkg;

  localparam int IO_DATA_W        = 8;
  localparam int IO_RX_FIFO_DEPTH = 4;
  localparam int IO_OVERSAMPLE    = 4;

  typedef logic [IO_DATA_W-1:0] io_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/i_o_input_buffer.sv
// Receive byte buffer: 4-entry circular FIFO when I_O_INPUT_FIFO_EN is defined,
// otherwise a single holding register. A pop in the same cycle frees room for a push.
module i_o_input_buffer
  import i_o_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [IO_DATA_W-1:0] push_data,
  input  logic                 pop,
  output logic [IO_DATA_W-1:0] head,
  output logic                 full,
  output logic                 empty,
  output logic                 overrun
);

  logic pop_eff;
  logic push_eff;

`ifdef I_O_INPUT_FIFO_EN
  localparam int PTR_W = $clog2(IO_RX_FIFO_DEPTH);

  logic [IO_DATA_W-1:0] mem [IO_RX_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_inc;
  logic [PTR_W:0]       count_reg;
  logic [IO_DATA_W-1:0] head_reg;

  assign full       = (count_reg == (PTR_W+1)'(IO_RX_FIFO_DEPTH));
  assign empty      = (count_reg == '0);
  assign pop_eff    = pop & ~empty;
  assign push_eff   = push & (~full | pop_eff);
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign head       = head_reg;

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // head_reg is a registered read of the next entry, bypassed when the FIFO drains to the new byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (pop_eff) begin
        if (count_reg > (PTR_W+1)'(1)) begin
          head_reg <= mem[rd_ptr_inc];
        end else if (push_eff) begin
          head_reg <= push_data;
        end
      end else if (push_eff && empty) begin
        head_reg <= push_data;
      end
    end
  end
`else
  logic [IO_DATA_W-1:0] data_reg;
  logic                 valid_reg;

  assign full     = valid_reg;
  assign empty    = ~valid_reg;
  assign pop_eff  = pop & valid_reg;
  assign push_eff = push & (~valid_reg | pop_eff);
  assign head     = data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (push_eff) begin
      data_reg  <= push_data;
      valid_reg <= 1'b1;
    end else if (pop_eff) begin
      valid_reg <= 1'b0;
    end
  end
`endif

  assign overrun = push & ~push_eff;

endmodule

// File: rtl/i_o_input_controller.sv
// Oversampling serial receiver (8N1) feeding a byte buffer with ready/ack handshake.
// Buffer depth is selected by macro I_O_INPUT_FIFO_EN (4-entry FIFO) vs. single register.
module i_o_input_controller
  import i_o_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       TXD,
  output logic [7:0] io_input_value,
  output logic       io_input_ready,
  input  logic       io_input_ack,
  output logic       io_input_frame_error,
  output logic       io_input_overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  logic [1:0] sync_reg;
  logic       line;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= TXD;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign line = sync_reg[1];

  rx_state_t            state_reg, state_next;
  logic [TICK_W-1:0]    tick_reg, tick_next;
  logic [2:0]           bit_reg, bit_next;
  io_byte_t             shift_reg, shift_next;
  logic                 brk_reg, brk_next;
  logic                 ferr_reg, ferr_next;
  logic                 ovr_reg;
  logic                 push;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 buf_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      brk_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      brk_reg   <= brk_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= buf_overrun;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    brk_next   = brk_reg;
    ferr_next  = 1'b0;
    push       = 1'b0;
    if (active) begin
      case (state_reg)
        IDLE: begin
          if (!line) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_reg == HALF_LAST) begin
            tick_next = '0;
            if (!line) begin
              state_next = DATA;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        DATA: begin
          if (tick_reg == FULL_LAST) begin
            tick_next  = '0;
            shift_next = {line, shift_reg[7:1]};
            if (bit_reg == 3'd7) state_next = STOP;
            else                 bit_next   = bit_reg + 1'b1;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        STOP: begin
          // After a bad stop bit, hold here until the line returns high (break).
          if (brk_reg) begin
            if (line) begin
              state_next = IDLE;
              brk_next   = 1'b0;
            end
          end else if (tick_reg == FULL_LAST) begin
            tick_next = '0;
            if (line) begin
              push       = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_next = 1'b1;
              brk_next  = 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  i_o_input_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_reg),
    .pop       (io_input_ack),
    .head      (io_input_value),
    .full      (buf_full),
    .empty     (buf_empty),
    .overrun   (buf_overrun)
  );

  assign io_input_ready       = ~buf_empty;
  assign io_input_frame_error = ferr_reg;
  assign io_input_overrun     = ovr_reg;

  logic unused_full;
  assign unused_full = buf_full;

endmodule

// File: tb/tb_i_o_input_controller.sv
// Directed bench for i_o_input_controller: OVERSAMPLE=4, active every 4th clk, 16 clk per bit.
module tb_i_o_input_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active = 1'b0;
  logic       TXD = 1'b1;
  logic [7:0] io_input_value;
  logic       io_input_ready;
  logic       io_input_ack = 1'b0;
  logic       io_input_frame_error;
  logic       io_input_overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int phase = 0;
  int ferr_base;
  int ovr_base;

  i_o_input_controller #(.OVERSAMPLE(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .active               (active),
    .TXD                  (TXD),
    .io_input_value       (io_input_value),
    .io_input_ready       (io_input_ready),
    .io_input_ack         (io_input_ack),
    .io_input_frame_error (io_input_frame_error),
    .io_input_overrun     (io_input_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      phase  = (phase + 1) % 4;
      active = (phase == 0);
    end
  end

  always @(negedge clk) begin
    if (io_input_frame_error) ferr_cnt++;
    if (io_input_overrun) ovr_cnt++;
    if (io_input_frame_error && io_input_overrun) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    TXD = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    $display("tx frame 0x%02h stop=%0b ready=%0b value=0x%02h", d, stop, io_input_ready, io_input_value);
  endtask

  task automatic ack_pop();
    io_input_ack = 1'b1;
    @(negedge clk);
    io_input_ack = 1'b0;
    $display("ack ready=%0b value=0x%02h", io_input_ready, io_input_value);
  endtask

  initial begin
    // Reset held two cycles
    idle(2);
    check("rst_ready", io_input_ready, 0);
    check("rst_ferr", io_input_frame_error, 0);
    check("rst_ovr", io_input_overrun, 0);
    check("rst_value", io_input_value, 8'h00);
    reset = 1'b0;
    idle(40);
    check("idle_ferr", ferr_cnt, 0);
    check("idle_ovr", ovr_cnt, 0);
    check("idle_ready", io_input_ready, 0);

    // Good frame 0xAA
    send_frame(8'hAA, 1'b1);
    check("aa_ready", io_input_ready, 1);
    check("aa_value", io_input_value, 8'hAA);
    ack_pop();
    check("aa_ack_ready", io_input_ready, 0);
    idle(16);

    // Short glitch on the line
    TXD = 1'b0;
    idle(8);
    TXD = 1'b1;
    idle(48);
    $display("glitch ready=%0b", io_input_ready);
    check("glitch_ready", io_input_ready, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);

    // Bad stop bit followed by a held-low break, then a good frame
    ferr_base = ferr_cnt;
    send_frame(8'h55, 1'b0);
    idle(40);
    TXD = 1'b1;
    idle(32);
    check("brk_ferr_cnt", ferr_cnt - ferr_base, 1);
    check("brk_ready", io_input_ready, 0);
    send_frame(8'h3C, 1'b1);
    check("3c_ready", io_input_ready, 1);
    check("3c_value", io_input_value, 8'h3C);
    ack_pop();
    check("3c_ack_ready", io_input_ready, 0);
    idle(16);

    // Overrun when the buffer fills without acks
    ovr_base = ovr_cnt;
`ifdef I_O_INPUT_FIFO_EN
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    check("fifo_ovr_4", ovr_cnt - ovr_base, 0);
    send_frame(8'h55, 1'b1);
    check("fifo_ovr_5", ovr_cnt - ovr_base, 1);
    check("fifo_v0", io_input_value, 8'h11);
    ack_pop();
    check("fifo_v1", io_input_value, 8'h22);
    ack_pop();
    check("fifo_v2", io_input_value, 8'h33);
    ack_pop();
    check("fifo_v3", io_input_value, 8'h44);
    check("fifo_rdy3", io_input_ready, 1);
    ack_pop();
    check("fifo_empty", io_input_ready, 0);
`else
    send_frame(8'h11, 1'b1);
    check("hold_ovr_1", ovr_cnt - ovr_base, 0);
    send_frame(8'h22, 1'b1);
    check("hold_ovr_2", ovr_cnt - ovr_base, 1);
    check("hold_value", io_input_value, 8'h11);
    check("hold_ready", io_input_ready, 1);
    ack_pop();
    check("hold_empty", io_input_ready, 0);
`endif
    idle(16);

    // Reset during data bit 4 of 0xF0, then 0x0F
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    TXD = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("mid_rst_ready", io_input_ready, 0);
    check("mid_rst_value", io_input_value, 8'h00);
    idle(64);
    check("mid_rst_noise", io_input_ready, 0);
    send_frame(8'h0F, 1'b1);
    check("0f_ready", io_input_ready, 1);
    check("0f_value", io_input_value, 8'h0F);
    ack_pop();
    check("0f_ack_ready", io_input_ready, 0);
    idle(32);
    check("mid_rst_ferr", ferr_cnt - ferr_base, 0);
    check("mid_rst_ovr", ovr_cnt - ovr_base, 0);
    check("flags_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
